// File: rtl/jtframe_sdram_pkg.sv
// Shared types and constants for the JTFRAME SDRAM responder: FSM states, data width and the read tag.
// The optional refresh-stall input is enabled with the macro JTFRAME_SDRAM_STALL_EN.
package jtframe_sdram_pkg;

    localparam int DW         = 16;
    localparam int MEMLAT_MIN = 1;
    localparam int MEMLAT_MAX = 15;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_WAIT  = ST_WAIT
    } state_t;

    typedef struct packed {
        logic valid;
        logic last;
    } tag_t;

endpackage

// File: rtl/jtframe_sdram_rsp_pipe.sv
// Tag delay line: carries {valid,last} alongside each memory read so the returning word
// can be qualified exactly when the backing memory presents it.
module jtframe_sdram_rsp_pipe
    import jtframe_sdram_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t tag_i,
    output tag_t tag_o
);

    tag_t stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/jtframe_sdram_rsp.sv
// Slot-side SDRAM read responder backed by a fixed-latency memory port.
// Define JTFRAME_SDRAM_STALL_EN to add the stall input that holds off new requests in IDLE.
//
// state  | meaning
// IDLE   | waiting for sdram_req (and no stall)
// ISSUE  | ack pulse, first read; second read follows when BURST=2
// WAIT   | draining the tag pipe until one cycle after data_rdy
module jtframe_sdram_rsp
    import jtframe_sdram_pkg::*;
#(
    parameter int SDRAMW = 22,
    parameter int BURST  = 2,
    parameter int MEMLAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef JTFRAME_SDRAM_STALL_EN
    input  logic              stall,
`endif
    input  logic              sdram_req,
    input  logic [SDRAMW-1:0] sdram_addr,
    output logic              sdram_ack,
    output logic              data_dst,
    output logic              data_rdy,
    output logic [DW-1:0]     data_read,
    output logic              mem_rd,
    output logic [SDRAMW-1:0] mem_addr,
    input  logic [DW-1:0]     mem_dout
);

    if (MEMLAT < MEMLAT_MIN || MEMLAT > MEMLAT_MAX) begin : g_bad_memlat
        $error("jtframe_sdram_rsp: MEMLAT out of range");
    end
    if (BURST != 1 && BURST != 2) begin : g_bad_burst
        $error("jtframe_sdram_rsp: BURST must be 1 or 2");
    end

    state_t              state_q, state_d;
    logic                ack_q, ack_d;
    logic                rd_q, rd_d;
    logic                last_q, last_d;
    logic [SDRAMW-1:0]   addr_q, addr_d;
    logic                dst_q, rdy_q, done_q;
    logic [DW-1:0]       read_q;
    logic                stall_w;
    tag_t                tag_in, tag_out;

`ifdef JTFRAME_SDRAM_STALL_EN
    assign stall_w = stall;
`else
    assign stall_w = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        rd_d    = 1'b0;
        last_d  = 1'b0;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (sdram_req && !stall_w) begin
                    state_d = S_ISSUE;
                    ack_d   = 1'b1;
                    rd_d    = 1'b1;
                    last_d  = (BURST == 1);
                    addr_d  = sdram_addr;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                if (BURST == 2) begin
                    rd_d   = 1'b1;
                    last_d = 1'b1;
                    addr_d = addr_q + SDRAMW'(1);
                end
            end
            S_WAIT: begin
                // done_q trails data_rdy by one cycle, so IDLE is reached the cycle after that
                if (done_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign tag_in = '{valid: rd_q, last: last_q};

    jtframe_sdram_rsp_pipe #(
        .DEPTH (MEMLAT)
    ) u_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
            rd_q    <= 1'b0;
            last_q  <= 1'b0;
            addr_q  <= '0;
            dst_q   <= 1'b0;
            rdy_q   <= 1'b0;
            done_q  <= 1'b0;
            read_q  <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            rd_q    <= rd_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            dst_q   <= tag_out.valid;
            rdy_q   <= tag_out.valid & tag_out.last;
            done_q  <= rdy_q;
            if (tag_out.valid) read_q <= mem_dout;
        end
    end

    assign sdram_ack = ack_q;
    assign mem_rd    = rd_q;
    assign mem_addr  = addr_q;
    assign data_dst  = dst_q;
    assign data_rdy  = rdy_q;
    assign data_read = read_q;

endmodule
